// File: rtl/md_pkg.sv
// Shared definitions for the parametrised multiply/divide unit:
// op encodings, FSM states and per-op latency lookup.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Reserved and single-cycle ops report zero latency.
  function automatic int op_latency(logic [3:0] op, int mul_lat, int div_lat);
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return mul_lat;
      OP_DIV, OP_DIVU: return div_lat;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/md_unit_param_if.sv
// E-stage to multiply/divide unit connection: op issue, flush and HI/LO/busy return.
interface md_unit_param_if #(parameter int WIDTH = 32);

  logic             start;
  logic [3:0]       md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (output start, md_op, a, b, flush, input hi, lo, busy);
  modport slave  (input start, md_op, a, b, flush, output hi, lo, busy);

endinterface

// File: rtl/md_arith.sv
// Combinational datapath: full-width product, accumulate and divide results
// for every long-running op, plus a flag marking which ops are long.
module md_arith import md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             is_long
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quo_u;
  logic [WIDTH-1:0]   rem_u;
  logic               div_zero;
  logic               div_ovf;

  assign acc    = {hi, lo};
  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign div_zero = (b == '0);
  assign div_ovf  = (a == MOST_NEG) && (b == '1);
  assign b_safe   = div_zero ? WIDTH'(1) : b;
  assign quo_s    = $signed(a) / $signed(b_safe);
  assign rem_s    = $signed(a) % $signed(b_safe);
  assign quo_u    = a / b_safe;
  assign rem_u    = a % b_safe;

  always_comb begin
    result  = acc;
    is_long = 1'b0;
    case (op)
      OP_MULT:  begin result = prod_s;       is_long = 1'b1; end
      OP_MULTU: begin result = prod_u;       is_long = 1'b1; end
      OP_MADD:  begin result = acc + prod_s; is_long = 1'b1; end
      OP_MADDU: begin result = acc + prod_u; is_long = 1'b1; end
      OP_MSUB:  begin result = acc - prod_s; is_long = 1'b1; end
      OP_MSUBU: begin result = acc - prod_u; is_long = 1'b1; end
      OP_DIV: begin
        is_long = 1'b1;
        if (div_zero)     result = acc;
        else if (div_ovf) result = {{WIDTH{1'b0}}, a};
        else              result = {rem_s, quo_s};
      end
      OP_DIVU: begin
        is_long = 1'b1;
        result  = div_zero ? acc : {rem_u, quo_u};
      end
      default: ;
    endcase
  end

  assign {res_hi, res_lo} = result;

endmodule

// File: rtl/md_unit_param.sv
// Multiply/divide unit owning HI/LO: latches a shadow result at issue,
// stays busy for the op latency, then commits unless flushed.
module md_unit_param import md_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             reset,
  md_unit_param_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_hi_q, shadow_hi_d;
  logic [WIDTH-1:0] shadow_lo_q, shadow_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             is_long;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op      (bus.md_op),
    .a       (bus.a),
    .b       (bus.b),
    .hi      (hi_q),
    .lo      (lo_q),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .is_long (is_long)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // Flush has priority over both a new issue and the commit edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (is_long) begin
            shadow_hi_d = res_hi;
            shadow_lo_d = res_lo;
            cnt_d       = CNT_W'(op_latency(bus.md_op, MUL_LAT, DIV_LAT));
            state_d     = BUSY;
          end else if (bus.md_op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.md_op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = shadow_hi_q;
          lo_d    = shadow_lo_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q == BUSY);

endmodule

// File: tb/tb_md_unit_param.sv
// Scoreboard bench for md_unit_param: stimulus pushes expected HI/LO and busy
// length from a reference model; a negedge monitor checks each completion.
module tb_md_unit_param;
  import md_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  typedef struct {
    logic [63:0] pre;
    logic [63:0] post;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;
  logic chk_req = 1'b0;
  logic busy_prev = 1'b0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  md_unit_param_if #(.WIDTH(WIDTH)) bus ();

  md_unit_param #(
    .WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic compare(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got unexpected event, want none", name);
  endtask

  function automatic logic is_long_op(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (op == OP_DIV || op == OP_DIVU) ? DIV_LAT : MUL_LAT;
  endfunction

  // Reference model in plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [63:0] acc);
    longint sx;
    logic [63:0] ps;
    logic [63:0] pu;
    int sa;
    int sbv;
    int q;
    int r;
    sx = longint'($signed(av));
    ps = sx * longint'($signed(bv));
    pu = 64'(av) * 64'(bv);
    sa = av;
    sbv = bv;
    case (op)
      OP_MULT:  return ps;
      OP_MULTU: return pu;
      OP_MADD:  return acc + ps;
      OP_MADDU: return acc + pu;
      OP_MSUB:  return acc - ps;
      OP_MSUBU: return acc - pu;
      OP_MTHI:  return {av, acc[31:0]};
      OP_MTLO:  return {acc[63:32], av};
      OP_DIV: begin
        if (bv == 32'd0) return acc;
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'd0, av};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      OP_DIVU: begin
        if (bv == 32'd0) return acc;
        return {av % bv, av / bv};
      end
      default: return acc;
    endcase
  endfunction

  // Monitor: hold check while busy, result and busy length at each completion
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy === 1'b1) begin
      busy_cnt++;
      if (sb.size() > 0) compare("hold_during_busy", {bus.hi, bus.lo}, sb[0].pre);
      else fail_now("busy_without_op");
    end else if (busy_prev || chk_req) begin
      if (sb.size() == 0) begin
        fail_now("spurious_completion");
      end else begin
        e = sb.pop_front();
        compare("hilo_result", {bus.hi, bus.lo}, e.post);
        if (e.len >= 0) compare("busy_length", 64'(busy_cnt), 64'(e.len));
      end
      busy_cnt = 0;
    end
    busy_prev = (bus.busy === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [3:0] op, input logic [31:0] av,
                             input logic [31:0] bv, input logic fl);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = av;
    bus.b     = bv;
    bus.flush = fl;
    tick();
    bus.start = 1'b0;
    bus.md_op = 4'd0;
    bus.flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_now("idle_timeout");
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] av,
                               input logic [31:0] bv, input int flush_at);
    exp_t e;
    e.pre = {ref_hi, ref_lo};
    if (is_long_op(op)) begin
      e.post = (flush_at > 0) ? e.pre : model(op, av, bv, e.pre);
      e.len  = (flush_at > 0) ? flush_at : lat_of(op);
      sb.push_back(e);
      drive_start(op, av, bv, 1'b0);
      if (flush_at > 0) begin
        repeat (flush_at - 1) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
      end else begin
        wait_idle();
      end
    end else begin
      e.post = model(op, av, bv, e.pre);
      e.len  = 0;
      sb.push_back(e);
      drive_start(op, av, bv, 1'b0);
      chk_req = 1'b1;
      tick();
      chk_req = 1'b0;
    end
    {ref_hi, ref_lo} = e.post;
  endtask

  task automatic applyIdleFlush(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    e.pre  = {ref_hi, ref_lo};
    e.post = e.pre;
    e.len  = 0;
    sb.push_back(e);
    drive_start(op, av, bv, 1'b1);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] want_hi, input logic [31:0] want_lo);
    compare(name, {bus.hi, bus.lo}, {want_hi, want_lo});
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [3:0] op;
    int fa;
    bus.start = 1'b0;
    bus.md_op = 4'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    reset     = 1'b0;
    repeat (3) tick();
    compare("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    compare("reset_busy", 64'(bus.busy), 64'd0);
    reset = 1'b1;
    tick();

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0);
    checkOutput("mult_signed", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    applyStimulus(OP_DIVU, 32'd7, 32'd2, 0);
    checkOutput("divu", 32'd1, 32'd3);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    checkOutput("div_signed", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus(OP_MTHI, 32'h1234_5678, 32'd0, 0);
    checkOutput("mthi", 32'h1234_5678, 32'hFFFF_FFFD);
    applyStimulus(OP_MTLO, 32'd0, 32'd0, 0);
    applyStimulus(OP_MADDU, 32'hFFFF_FFFF, 32'd2, 0);
    checkOutput("maddu", 32'h1234_5679, 32'hFFFF_FFFE);
    applyStimulus(OP_MTHI, 32'hAA, 32'd0, 0);
    applyStimulus(OP_MTLO, 32'hBB, 32'd0, 0);
    applyStimulus(OP_DIV, 32'd123, 32'd0, 0);
    checkOutput("div_by_zero", 32'hAA, 32'hBB);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    checkOutput("div_overflow", 32'd0, 32'h8000_0000);

    // Flush in cycle T+3, then an immediate reissue
    applyStimulus(OP_MULT, 32'd7, 32'd9, 3);
    checkOutput("flush_keeps", 32'd0, 32'h8000_0000);
    applyStimulus(OP_MULTU, 32'd10, 32'd20, 0);
    checkOutput("after_flush", 32'd0, 32'd200);
    applyStimulus(OP_MSUB, 32'd3, 32'd4, 0);
    checkOutput("msub", 32'd0, 32'd188);
    applyStimulus(OP_NONE, 32'd1, 32'd1, 0);
    applyStimulus(4'd12, 32'd1, 32'd1, 0);
    applyIdleFlush(OP_MULT, 32'd5, 32'd5);
    applyIdleFlush(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    applyStimulus(OP_MULT, 32'd2, 32'd3, MUL_LAT);

    // Second start while busy must be ignored
    e.pre  = {ref_hi, ref_lo};
    e.post = model(OP_MULT, 32'd3, 32'd4, e.pre);
    e.len  = MUL_LAT;
    sb.push_back(e);
    drive_start(OP_MULT, 32'd3, 32'd4, 1'b0);
    tick();
    drive_start(OP_MULT, 32'd100, 32'd100, 1'b0);
    wait_idle();
    {ref_hi, ref_lo} = e.post;
    checkOutput("ignored_start", 32'd0, 32'd12);

    // Asynchronous reset in cycle T+4 of a divide
    e.pre  = {ref_hi, ref_lo};
    e.post = 64'd0;
    e.len  = -1;
    sb.push_back(e);
    drive_start(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (3) tick();
    #1 reset = 1'b0;
    #1;
    compare("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    compare("async_reset_busy", 64'(bus.busy), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    ref_hi = '0;
    ref_lo = '0;

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) begin
        applyIdleFlush(op, pick_val(), pick_val());
      end else begin
        fa = 0;
        if (is_long_op(op) && $urandom_range(0, 4) == 0) fa = $urandom_range(1, lat_of(op));
        applyStimulus(op, pick_val(), pick_val(), fa);
      end
    end

    repeat (3) tick();
    compare("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised successor to the pipeline's multiply/divide unit; sits in the E stage beside the ALU.
- Owns the HI/LO registers and drives `busy` to the stall logic in the control unit.
- Generalised in operand width and in independent multiply/divide latencies.
- Adds behaviour the original unit lacks: multiply-accumulate (madd/maddu/msub/msubu), defined divide-by-zero handling, and a pipeline-flush cancel.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>= 8).
- MUL_LAT, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (>= 1).
- DIV_LAT, 10, busy cycles for div/divu (>= 1).
- CNT_W, 8, latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  op valid this cycle (E-stage instruction is an MD op).
- md_op  input  4  operation code, encodings in the package.
- a  input  WIDTH  rs operand, already forwarded.
- b  input  WIDTH  rt operand, already forwarded.
- flush  input  1  cancel any in-flight operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in flight; the CU stalls MD instructions in D while busy or while start is high.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, state=IDLE, counter=0, shadow registers=0.
- States: IDLE and BUSY.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU}:
  - Compute the 2*WIDTH result combinationally from a/b (plus current {hi,lo} for the accumulate ops) and latch it into shadow_hi/shadow_lo.
  - Load counter with the op's LAT; go to BUSY.
  - busy rises in cycle T+1 (start in cycle T).
- BUSY: counter decrements each cycle.
  - When counter==1, the next edge commits shadow to hi/lo and returns to IDLE.
  - busy is high for exactly LAT cycles (T+1..T+LAT); new hi/lo are visible from cycle T+LAT+1.
- MTHI/MTLO with start=1 in IDLE: hi<=a or lo<=a on the next edge, no busy, single cycle.
- MFHI/MFLO are not ops here: E stage reads the hi/lo ports directly. During BUSY, hi/lo keep their pre-op values.
- start=1 while BUSY: ignored. The CU guarantees no such issue; the bench must check that no state changes.
- NONE op with start=1: no effect.
- Arithmetic:
  - mult: signed WIDTH x WIDTH -> 2*WIDTH, {hi,lo}=product.
  - multu: unsigned.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - madd/maddu: {hi,lo} += product (signed/unsigned), modulo 2^(2*WIDTH).
  - msub/msubu: {hi,lo} -= product, modulo 2^(2*WIDTH).
  - The accumulator base is {hi,lo} sampled at start.
- Divide by zero (b==0):
  - Still enters BUSY for DIV_LAT cycles.
  - Commit leaves hi/lo unchanged (shadow loaded with current hi/lo).
- Signed overflow div (a=most-negative, b=-1): lo=a, hi=0; no trap.
- flush=1:
  - In BUSY: abort on the next edge, return to IDLE, busy=0, hi/lo keep their pre-op values, no commit.
  - In IDLE: suppresses any start in the same cycle.
  - flush and the commit edge in the same cycle: flush wins, no commit.
- Reset mid-operation: immediate return to the reset values; no commit.

Decomposition:
- Shared package md_pkg holds:
  - md_op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10; 11-15 reserved and treated as NONE.
  - State enum IDLE/BUSY.
  - Function returning the latency for an op.
- One natural sub-module, md_arith: purely combinational; given op, a, b, hi, lo it returns {res_hi, res_lo, is_long}.
- The top level holds the FSM, counter, shadow registers and HI/LO.

Test Plan:
- WIDTH=32, MUL_LAT=5: start MULT, a=0xFFFFFFFD (-3), b=5 -> busy high cycles T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFF1 from T+6; hi/lo unchanged during busy.
- DIVU a=7, b=2 -> busy 10 cycles, then lo=3, hi=1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy never rises. Then MADDU a=0xFFFFFFFF, b=2 with lo=0 -> {hi,lo}=0x12345679_FFFFFFFE.
- DIV b=0 with hi=0xAA, lo=0xBB -> busy 10 cycles, then hi=0xAA, lo=0xBB.
- MULT started, flush at cycle T+3 -> busy low from T+4, hi/lo keep their old values; a later start at T+4 proceeds normally.
- DIVU in flight, reset low at T+4 -> hi=lo=0 and busy=0 immediately, without waiting for a clk edge. start while busy (second MULT at T+2) -> ignored, the first result commits intact.
